// File: rtl/cim_pkg.sv
// Shared encodings and defaults for the CIM sequencer and the core-side decoder.
package cim_pkg;

    localparam int DW_DEF      = 32;
    localparam int AW_DEF      = 8;
    localparam int NREG_DEF    = 16;
    localparam int ACCW_DEF    = 32;
    localparam int MAC_LAT_DEF = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        OP_WR         = 3'd0,
        OP_COMP       = 3'd1,
        OP_RD         = 3'd2,
        OP_REG_RD     = 3'd3,
        OP_REG_RESET  = 3'd4,
        OP_COMP_SHIFT = 3'd5
    } cim_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } cim_state_e;

    function automatic logic is_mac_op(input logic [2:0] op);
        return (op == OP_COMP) || (op == OP_COMP_SHIFT);
    endfunction

endpackage

// File: rtl/cim_acc_bank.sv
// Bank of NREG accumulators with clear-all, add / shift-add update and one read port.
module cim_acc_bank
    import cim_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int DW   = DW_DEF,
    localparam int RW  = $clog2(NREG)
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 clr,
    input  logic                 upd,
    input  logic                 shift,
    input  logic [RW-1:0]        idx,
    input  logic signed [DW-1:0] mac_val,
    output logic [DW-1:0]        rd_data,
    output logic [DW-1:0]        nxt_data
);

    logic [ACCW-1:0] acc [NREG];
    logic [ACCW-1:0] cur;
    logic [ACCW-1:0] nxt;

    // Sign-extend the partial sum and accumulate; wraps modulo 2^ACCW.
    function automatic logic [ACCW-1:0] mac_accum(input logic [ACCW-1:0] a,
                                                  input logic sh,
                                                  input logic signed [DW-1:0] m);
        logic signed [ACCW-1:0] m_ext;
        m_ext = ACCW'(m);
        return (sh ? (a << 1) : a) + m_ext;
    endfunction

    assign cur      = acc[idx];
    assign nxt      = mac_accum(cur, shift, mac_val);
    assign rd_data  = cur[DW-1:0];
    assign nxt_data = nxt[DW-1:0];

    always_ff @(posedge CLK) begin
        if (RES || clr) begin
            for (int i = 0; i < NREG; i++) begin
                acc[i] <= '0;
            end
        end else if (upd) begin
            acc[idx] <= nxt;
        end
    end

endmodule

// File: rtl/cim_seq_ctrl.sv
// Command sequencer for a compute-in-memory array: write, read, MAC and accumulator ops.
module cim_seq_ctrl
    import cim_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int ACCW    = ACCW_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    localparam int RW     = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic [RW-1:0] cmd_reg,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy,
    output logic          arr_we,
    output logic          arr_re,
    output logic          arr_mac_en,
    output logic [AW-1:0] arr_addr,
    output logic [DW-1:0] arr_wdata,
    output logic [DW-1:0] arr_mac_in,
    input  logic [DW-1:0] arr_rdata,
    input  logic [DW-1:0] arr_mac_out
);

    cim_state_e       state;
    logic [2:0]       op_p0;
    logic [RW-1:0]    reg_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic          acc_clr;
    logic          acc_upd;
    logic          acc_shift;
    logic [RW-1:0] acc_idx;
    logic [DW-1:0] acc_rd;
    logic [DW-1:0] acc_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // In IDLE the bank is addressed straight from the command so REG_RD can answer next cycle.
    assign acc_idx   = (state == S_IDLE) ? cmd_reg : reg_p0;
    assign acc_clr   = (state == S_IDLE) && cmd_valid && (cmd_op == OP_REG_RESET);
    assign acc_upd   = (state == S_WAIT) && (cnt_p0 == '0) && is_mac_op(op_p0);
    assign acc_shift = (op_p0 == OP_COMP_SHIFT);

    cim_acc_bank #(
        .NREG (NREG),
        .ACCW (ACCW),
        .DW   (DW)
    ) u_acc_bank (
        .CLK      (CLK),
        .RES      (RES),
        .clr      (acc_clr),
        .upd      (acc_upd),
        .shift    (acc_shift),
        .idx      (acc_idx),
        .mac_val  (arr_mac_out),
        .rd_data  (acc_rd),
        .nxt_data (acc_nxt)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= S_IDLE;
            op_p0      <= '0;
            reg_p0     <= '0;
            cnt_p0     <= '0;
            arr_we     <= 1'b0;
            arr_re     <= 1'b0;
            arr_mac_en <= 1'b0;
            arr_addr   <= '0;
            arr_wdata  <= '0;
            arr_mac_in <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                // Acceptance: capture the command and pre-load the issue-cycle strobes.
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_p0  <= cmd_op;
                        reg_p0 <= cmd_reg;
                        case (cmd_op)
                            OP_WR: begin
                                state     <= S_ISSUE;
                                arr_we    <= 1'b1;
                                arr_addr  <= cmd_addr;
                                arr_wdata <= cmd_data;
                            end
                            OP_RD: begin
                                state    <= S_ISSUE;
                                arr_re   <= 1'b1;
                                arr_addr <= cmd_addr;
                            end
                            OP_COMP, OP_COMP_SHIFT: begin
                                state      <= S_ISSUE;
                                arr_mac_en <= 1'b1;
                                arr_addr   <= cmd_addr;
                                arr_mac_in <= cmd_data;
                            end
                            OP_REG_RD: begin
                                state     <= S_DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= acc_rd;
                            end
                            OP_REG_RESET: begin
                                state     <= S_DONE;
                                rsp_valid <= 1'b1;
                            end
                            default: begin
                                state     <= S_DONE;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                // Issue: strobes are live for exactly this cycle.
                S_ISSUE: begin
                    arr_we     <= 1'b0;
                    arr_re     <= 1'b0;
                    arr_mac_en <= 1'b0;
                    arr_addr   <= '0;
                    arr_wdata  <= '0;
                    arr_mac_in <= '0;
                    if (op_p0 == OP_WR) begin
                        state <= S_IDLE;
                    end else begin
                        state  <= S_WAIT;
                        cnt_p0 <= (op_p0 == OP_RD) ? '0 : CNT_W'(MAC_LAT - 1);
                    end
                end
                // Wait: the last count is the cycle the array result is valid.
                S_WAIT: begin
                    if (cnt_p0 == '0) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (op_p0 == OP_RD) ? arr_rdata : acc_nxt;
                    end else begin
                        cnt_p0 <= cnt_p0 - CNT_W'(1);
                    end
                end
                // Done: single response pulse, then back to IDLE.
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
